hc_enc_stream: RTL and testbench



---
 rtl/hc_enc_stream.sv | 130 +++++++++++++
 tb/tb_hc_enc_stream.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_enc_stream.sv
// hc_enc_stream: streaming Hamming encoder with one registered output stage,
// a skid buffer for full throughput under backpressure, optional per-word
// single-bit error injection and a wrapping emitted-codeword counter.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and its payload steady until that edge.
// o_ready is a pure register output (no path from i_ready). o_valid/o_enc_data
// stay steady while o_valid && !i_ready.
module hc_enc_stream #(
  parameter int DATA_WD = 4,
  parameter int CHK_WD  = 3,
  parameter int CNT_WD  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DATA_WD-1:0]         i_data,
  input  logic [CHK_WD-1:0]          i_inj_pos,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_WD+CHK_WD-1:0]  o_enc_data,
  output logic [CNT_WD-1:0]          o_cnt
);

  localparam int N = DATA_WD + CHK_WD;

  // Check bits need a distinct nonzero syndrome for every codeword position.
  if ((2 ** CHK_WD) < (N + 1)) begin : g_bad_param
    $error("hc_enc_stream: CHK_WD too small for DATA_WD");
  end

  // Data bit index held at codeword position j, or -1 for a check position.
  function automatic int data_idx(input int j);
    int k;
    k = 0;
    if ((j & (j - 1)) == 0) return -1;
    for (int p = 1; p < j; p++) begin
      if ((p & (p - 1)) != 0) k++;
    end
    return k;
  endfunction

  // Data positions covered by the check bit at position c (c a power of two).
  function automatic logic [N-1:0] chk_mask(input int c);
    logic [N-1:0] m;
    m = '0;
    for (int p = 1; p <= N; p++) begin
      if (((p & (p - 1)) != 0) && ((p & c) != 0)) m = m | (N'(1) << (p - 1));
    end
    return m;
  endfunction

  logic [N-1:0] dplace;    // data bits at their codeword positions, checks 0
  logic [N-1:0] enc_cw;    // clean codeword
  logic [N-1:0] flip;      // one-hot injection mask (all zero if out of range)
  logic [N-1:0] enc_word;  // codeword as stored
  logic         in_fire;
  logic         out_fire;
  logic         adv;

  logic         out_vld;
  logic [N-1:0] out_data;
  logic         skd_vld;
  logic [N-1:0] skd_data;
  logic [CNT_WD-1:0] cnt;

  // Per-position wiring: data placement, check parity, injection select.
  for (genvar j = 1; j <= N; j++) begin : g_pos
    localparam int DI = data_idx(j);
    if (DI >= 0 && DI < DATA_WD) begin : g_d
      assign dplace[j-1] = i_data[DI];
    end else begin : g_z
      assign dplace[j-1] = 1'b0;
    end
    if ((j & (j - 1)) == 0) begin : g_chk
      assign enc_cw[j-1] = ^(dplace & chk_mask(j));
    end else begin : g_dat
      assign enc_cw[j-1] = dplace[j-1];
    end
    // Position 0 never matches, and positions above N do not exist here.
    assign flip[j-1] = (i_inj_pos == CHK_WD'(j));
  end

  assign enc_word = enc_cw ^ flip;

  assign o_ready    = !skd_vld;
  assign o_valid    = out_vld;
  assign o_enc_data = out_data;
  assign o_cnt      = cnt;

  assign in_fire  = i_valid && o_ready;
  assign out_fire = out_vld && i_ready;
  assign adv      = !out_vld || i_ready;

  // Output stage plus skid: skid drains first, so order is preserved.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      skd_vld  <= 1'b0;
      skd_data <= '0;
    end else if (adv) begin
      if (skd_vld) begin
        out_data <= skd_data;
        out_vld  <= 1'b1;
        skd_vld  <= 1'b0;
      end else if (in_fire) begin
        out_data <= enc_word;
        out_vld  <= 1'b1;
      end else begin
        out_vld  <= 1'b0;
      end
    end else if (in_fire) begin
      // Output is stalled and full: park the new codeword in the skid.
      skd_data <= enc_word;
      skd_vld  <= 1'b1;
    end
  end

  // Count codewords taken downstream; wraps silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (out_fire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hc_enc_stream.sv
// tb_hc_enc_stream: scoreboard bench for hc_enc_stream. Expected codewords come
// from a syndrome-based reference model; a monitor pops them on every output
// transfer. A second, wider instance covers out-of-range injection and
// counter wrap.
module tb_hc_enc_stream;

  localparam int DW    = 4;
  localparam int CW    = 3;
  localparam int N     = DW + CW;
  localparam int CNTW  = 16;
  localparam int WDW   = 11;
  localparam int WCW   = 5;
  localparam int WN    = WDW + WCW;
  localparam int WCNTW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic [CW-1:0] i_inj_pos;
  logic          o_valid;
  logic          i_ready;
  logic [N-1:0]  o_enc_data;
  logic [CNTW-1:0] o_cnt;

  logic           w_valid;
  logic           w_oready;
  logic [WDW-1:0] w_data;
  logic [WCW-1:0] w_inj;
  logic           w_ovalid;
  logic           w_iready;
  logic [WN-1:0]  w_enc;
  logic [WCNTW-1:0] w_cnt;

  int total = 0;
  int bad   = 0;

  logic [N-1:0]  exp_q[$];
  logic [DW-1:0] dat_q[$];
  int            inj_q[$];
  int            fires = 0;
  logic          stall_prev = 1'b0;
  logic [N-1:0]  stall_data;
  logic          stress_done;

  hc_enc_stream #(.DATA_WD(DW), .CHK_WD(CW), .CNT_WD(CNTW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_inj_pos(i_inj_pos), .o_valid(o_valid),
    .i_ready(i_ready), .o_enc_data(o_enc_data), .o_cnt(o_cnt)
  );

  hc_enc_stream #(.DATA_WD(WDW), .CHK_WD(WCW), .CNT_WD(WCNTW)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(w_valid), .o_ready(w_oready),
    .i_data(w_data), .i_inj_pos(w_inj), .o_valid(w_ovalid),
    .i_ready(w_iready), .o_enc_data(w_enc), .o_cnt(w_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic bit_at(input logic [31:0] v, input int pos);
    return ((v >> pos) & 32'd1) != 0;
  endfunction

  // Place data in the non-power-of-two positions, then choose check bits so
  // the XOR of all set positions is zero; finally apply injection.
  function automatic logic [31:0] model_cw(input int dw, input int n,
                                           input logic [31:0] data, input int inj);
    logic [31:0] cw;
    int s;
    int d;
    cw = 0; s = 0; d = 0;
    for (int j = 1; j <= n; j++) begin
      if ((j & (j - 1)) != 0) begin
        if (d < dw && bit_at(data, d)) begin
          cw = cw | (32'd1 << (j - 1));
          s  = s ^ j;
        end
        d++;
      end
    end
    for (int j = 1; j <= n; j++) begin
      if ((j & (j - 1)) == 0 && (s & j) != 0) cw = cw | (32'd1 << (j - 1));
    end
    if (inj >= 1 && inj <= n) cw = cw ^ (32'd1 << (inj - 1));
    return cw;
  endfunction

  function automatic int syndrome(input int n, input logic [31:0] cw);
    int s;
    s = 0;
    for (int j = 1; j <= n; j++) if (bit_at(cw, j - 1)) s = s ^ j;
    return s;
  endfunction

  function automatic logic [31:0] recover(input int dw, input int n, input logic [31:0] cw);
    int s;
    int d;
    logic [31:0] r;
    s = syndrome(n, cw); d = 0; r = 0;
    if (s >= 1 && s <= n) cw = cw ^ (32'd1 << (s - 1));
    for (int j = 1; j <= n; j++) begin
      if ((j & (j - 1)) != 0) begin
        if (d < dw && bit_at(cw, j - 1)) r = r | (32'd1 << d);
        d++;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] tmp;
    logic [N-1:0] ecw;
    logic [DW-1:0] edat;
    int einj;
    if (!rst_n) begin
      exp_q.delete(); dat_q.delete(); inj_q.delete();
      fires = 0;
      stall_prev = 1'b0;
    end else begin
      check("cnt", o_cnt, fires[CNTW-1:0]);
      if (stall_prev) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_enc_data, stall_data);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_output: got=%0h want=none", o_enc_data);
        end else begin
          ecw = exp_q.pop_front(); edat = dat_q.pop_front(); einj = inj_q.pop_front();
          check("codeword", o_enc_data, ecw);
          check("syndrome", syndrome(N, o_enc_data), einj);
          check("recovered", recover(DW, N, o_enc_data), edat);
        end
        fires++;
      end
      stall_prev = o_valid && !i_ready;
      stall_data = o_enc_data;
      if (i_valid && o_ready) begin
        tmp = model_cw(DW, N, i_data, int'(i_inj_pos));
        exp_q.push_back(tmp[N-1:0]);
        dat_q.push_back(i_data);
        inj_q.push_back((int'(i_inj_pos) <= N) ? int'(i_inj_pos) : 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one word and hold it until accepted; returns 1 time unit after
  // the accepting edge.
  task automatic drive_word(input logic [DW-1:0] d, input logic [CW-1:0] inj);
    logic acc;
    logic to;
    int budget;
    acc = 1'b0; to = 1'b0; budget = 0;
    i_valid = 1'b1; i_data = d; i_inj_pos = inj;
    while (!acc && !to) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk); #1;
      budget++;
      if (!acc && budget > 200) begin
        to = 1'b1;
        total++; bad++;
        $display("FAIL accept_timeout: got=stalled want=accepted");
      end
    end
    i_valid = 1'b0; i_data = 'x; i_inj_pos = 'x;
  endtask

  // Check the codeword shown on the next negedge, then realign to edge+1.
  task automatic exp_const(input string name, input logic [N-1:0] want);
    @(negedge clk);
    check({name, "_valid"}, o_valid, 1);
    check(name, o_enc_data, want);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    @(posedge clk); #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    total++; bad++;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] m;
    logic [WDW-1:0] wd;
    int wi;
    rst_n = 1'b0;
    i_valid = 1'b0; i_ready = 1'b1; i_data = '0; i_inj_pos = '0;
    w_valid = 1'b0; w_iready = 1'b1; w_data = '0; w_inj = '0;
    stress_done = 1'b0;
    #23 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_cnt", o_cnt, 0);
    check("rst_data", o_enc_data, 0);
    check("rst_w_cnt", w_cnt, 0);
    @(posedge clk); #1;

    // Known vectors, no injection, no backpressure
    drive_word(4'b1011, 3'd0); exp_const("enc_1011", 7'h55);
    drive_word(4'b0001, 3'd0); exp_const("enc_0001", 7'h07);
    drive_word(4'b1111, 3'd0); exp_const("enc_1111", 7'h7F);
    drive_word(4'b0000, 3'd0); exp_const("enc_0000", 7'h00);
    @(negedge clk);
    check("cnt_after4", o_cnt, 4);
    @(posedge clk); #1;

    // Injection
    drive_word(4'b1011, 3'd5); exp_const("inj5", 7'h45);
    drive_word(4'b1011, 3'd0); exp_const("inj0", 7'h55);

    // Backpressure: two words fill out+skid, third waits
    i_ready = 1'b0;
    drive_word(4'h1, 3'd0);
    drive_word(4'h2, 3'd0);
    check("bp_ready_low", o_ready, 0);
    m = model_cw(DW, N, 1, 0);
    fork
      drive_word(4'h3, 3'd0);
      begin
        @(negedge clk);
        check("bp_stall_a", o_enc_data, m);
        check("bp_ready_a", o_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("bp_stall_b", o_enc_data, m);
        check("bp_ready_b", o_ready, 0);
        @(posedge clk); #1;
        i_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          check("bp_seq_valid", o_valid, 1);
          check("bp_seq_data", o_enc_data, model_cw(DW, N, k, 0));
        end
      end
    join
    @(posedge clk); #1;
    drain();

    // Random stress
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          drive_word(DW'($urandom_range(0, 15)), CW'($urandom_range(0, 7)));
        end
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          @(posedge clk); #1;
          i_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    // Wide instance: out-of-range injection and 4-bit counter wrap
    for (int k = 0; k < 17; k++) begin
      wd = WDW'($urandom_range(0, 2047));
      wi = (k == 0) ? 17 : $urandom_range(0, 16);
      w_valid = 1'b1; w_data = wd; w_inj = WCW'(wi);
      @(posedge clk); #1;
      w_valid = 1'b0;
      @(negedge clk);
      check("w_valid", w_ovalid, 1);
      check("w_cw", w_enc, model_cw(WDW, WN, wd, wi));
      check("w_syn", syndrome(WN, w_enc), (wi > WN) ? 0 : wi);
      if (k == 16) check("w_cnt_pre_wrap", w_cnt, 0);
    end
    @(posedge clk); #1;
    check("w_cnt_wrap", w_cnt, 1);

    // Reset with output and skid both full
    i_ready = 1'b0;
    drive_word(4'hA, 3'd0);
    drive_word(4'h6, 3'd2);
    check("pre_rst_valid", o_valid, 1);
    check("pre_rst_ready", o_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", o_valid, 0);
    check("async_rst_cnt", o_cnt, 0);
    check("async_rst_ready", o_ready, 1);
    check("async_rst_w_cnt", w_cnt, 0);
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    i_ready = 1'b1;
    #1;
    check("post_rst_ready", o_ready, 1);
    @(negedge clk);
    check("post_rst_no_stale", o_valid, 0);
    @(posedge clk); #1;
    drive_word(4'hC, 3'd3);
    exp_const("post_rst_word", model_cw(DW, N, 4'hC, 3));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
